// File: rtl/top_gpio_pkg.sv
// ============================================================================
// Module   : top_gpio_pkg
// Brief    : Address map, widths and register-select decode for top_gpio.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package top_gpio_pkg;

  localparam int unsigned c_in_w  = 13;
  localparam int unsigned c_out_w = 8;
  localparam int unsigned c_cnt_w = 8;

  localparam logic [13:0] c_addr_dfilt  = 14'h000;
  localparam logic [13:0] c_addr_refdiv = 14'h004;
  localparam logic [13:0] c_addr_in     = 14'h010;
  localparam logic [13:0] c_addr_out    = 14'h020;

  typedef enum logic [2:0] {
    SEL_NONE   = 3'd0,
    SEL_DFILT  = 3'd1,
    SEL_REFDIV = 3'd2,
    SEL_IN     = 3'd3,
    SEL_OUT    = 3'd4
  } reg_sel_e;

  // Decode operates on the word index; byte offset bits never reach here.
  function automatic reg_sel_e decode_word(input logic [11:0] word);
    reg_sel_e r;
    r = SEL_NONE;
    if (word == c_addr_dfilt[13:2])  r = SEL_DFILT;
    if (word == c_addr_refdiv[13:2]) r = SEL_REFDIV;
    if (word == c_addr_in[13:2])     r = SEL_IN;
    if (word == c_addr_out[13:2])    r = SEL_OUT;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gpio_dfilter.sv
// ============================================================================
// Module   : gpio_dfilter
// Brief    : One GPIO input bit: 2-flop synchronizer plus tick-driven
//            debounce filter (filter present only with GPIO_DFILTER_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpio_dfilter
  import top_gpio_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_pin,
  input  logic               i_tick,
  input  logic [c_cnt_w-1:0] i_dfilt,
  output logic               o_in
);

  logic r_sync1;
  logic r_sync2;

`ifdef GPIO_DFILTER_EN
  logic               r_in;
  logic [c_cnt_w-1:0] r_cnt;
  logic [c_cnt_w:0]   w_cnt_inc;

  // One extra bit so the compare can never wrap.
  assign w_cnt_inc = {1'b0, r_cnt} + {{c_cnt_w{1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_in    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_pin;
      r_sync2 <= r_sync1;
      if (i_tick) begin
        if (r_sync2 == r_in) begin
          r_cnt <= '0;
        end else if (w_cnt_inc >= {1'b0, i_dfilt}) begin
          r_in  <= r_sync2;
          r_cnt <= '0;
        end else begin
          r_cnt <= w_cnt_inc[c_cnt_w-1:0];
        end
      end
    end
  end

  assign o_in = r_in;
`else
  logic w_unused;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_pin;
      r_sync2 <= r_sync1;
    end
  end

  assign o_in     = r_sync2;
  assign w_unused = ^{i_tick, i_dfilt};
`endif

endmodule

`default_nettype wire

// File: rtl/top_gpio.sv
// ============================================================================
// Module   : top_gpio
// Brief    : GPIO block with register file, output port and filtered inputs;
//            input filter/prescaler enabled by macro GPIO_DFILTER_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module top_gpio
  import top_gpio_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [c_in_w-1:0]  gpio_pin_in,
  output logic [c_out_w-1:0] gpio_pin_out,
  input  logic               sel,
  input  logic [13:0]        addr,
  input  logic [3:0]         we,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata
);

  logic [c_cnt_w-1:0] r_dfilt;
  logic [c_cnt_w-1:0] r_refdiv;
  logic [c_out_w-1:0] r_out;
  logic [c_in_w-1:0]  w_in;
  logic               w_tick;
  reg_sel_e           w_sel;
  logic               w_unused;

  assign w_sel    = decode_word(addr[13:2]);
  assign w_unused = ^{we[3:1], wdata[31:8], addr[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dfilt  <= '0;
      r_refdiv <= '0;
      r_out    <= '0;
    end else if (sel && we[0]) begin
      case (w_sel)
        SEL_DFILT:  r_dfilt  <= wdata[7:0];
        SEL_REFDIV: r_refdiv <= wdata[7:0];
        SEL_OUT:    r_out    <= wdata[7:0];
        default:    ;
      endcase
    end
  end

  always_comb begin
    rdata = 32'h0;
    if (sel) begin
      case (w_sel)
        SEL_DFILT:  rdata = {24'h0, r_dfilt};
        SEL_REFDIV: rdata = {24'h0, r_refdiv};
        SEL_IN:     rdata = {19'h0, w_in};
        SEL_OUT:    rdata = {24'h0, r_out};
        default:    rdata = 32'h0;
      endcase
    end
  end

  assign gpio_pin_out = r_out;

`ifdef GPIO_DFILTER_EN
  logic [c_cnt_w-1:0] r_pre;
  logic [c_cnt_w-1:0] r_div_act;

  // The divider in use is only refreshed at wrap so a period is never cut short.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre     <= '0;
      r_div_act <= '0;
    end else if (r_pre >= r_div_act) begin
      r_pre     <= '0;
      r_div_act <= r_refdiv;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

  assign w_tick = (r_pre >= r_div_act);
`else
  assign w_tick = 1'b0;
`endif

  generate
    for (genvar i = 0; i < c_in_w; i++) begin : g_dfilter
      gpio_dfilter u_dfilter (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_pin   (gpio_pin_in[i]),
        .i_tick  (w_tick),
        .i_dfilt (r_dfilt),
        .o_in    (w_in[i])
      );
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_top_gpio.sv
// ============================================================================
// Module   : tb_top_gpio
// Brief    : Directed, table-driven self-checking bench for top_gpio.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_top_gpio;

  logic        clk;
  logic        rst_n;
  logic [12:0] gpio_pin_in;
  logic [7:0]  gpio_pin_out;
  logic        sel;
  logic [13:0] addr;
  logic [3:0]  we;
  logic [31:0] wdata;
  logic [31:0] rdata;

  int n_checks = 0;
  int n_errors = 0;

  top_gpio dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .gpio_pin_in  (gpio_pin_in),
    .gpio_pin_out (gpio_pin_out),
    .sel          (sel),
    .addr         (addr),
    .we           (we),
    .wdata        (wdata),
    .rdata        (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [13:0] a, input logic [31:0] d, input logic [3:0] w);
    @(negedge clk);
    sel = 1'b1; addr = a; wdata = d; we = w;
    @(posedge clk);
    #1;
    we = 4'b0000;
  endtask

  task automatic bus_read(input string name, input logic [13:0] a, input logic [31:0] exp);
    @(negedge clk);
    sel = 1'b1; addr = a; we = 4'b0000;
    #1;
    check(name, rdata, exp);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  vec_t        vecs[12];
  logic [31:0] pats[4];
  logic [13:0] regs[3];
  logic [12:0] pin_pats[4];

  initial begin
    pats = '{32'hAAAAAAAA, 32'hFFFFFFFF, 32'h00000000, 32'h55555555};
    regs = '{14'h000, 14'h004, 14'h020};
    pin_pats = '{13'h1FFF, 13'h1555, 13'h0AAA, 13'h0000};
    for (int p = 0; p < 4; p++)
      for (int r = 0; r < 3; r++)
        vecs[p*3+r] = '{regs[r], pats[p], {24'h0, pats[p][7:0]}};

    rst_n = 1'b0; sel = 1'b0; addr = '0; we = '0; wdata = '0; gpio_pin_in = '0;
    wait_clk(3);
    rst_n = 1'b1;

    // Reset state
    bus_read("rst_dfilt",  14'h000, 32'h0);
    bus_read("rst_refdiv", 14'h004, 32'h0);
    bus_read("rst_in",     14'h010, 32'h0);
    bus_read("rst_out",    14'h020, 32'h0);
    check("rst_pin_out", {24'h0, gpio_pin_out}, 32'h0);

    // Write/readback table
    for (int i = 0; i < 12; i++) begin
      bus_write(vecs[i].addr, vecs[i].wdata, 4'b0001);
      bus_read($sformatf("rdbk_%0d", i), vecs[i].addr, vecs[i].exp);
      if (vecs[i].addr == 14'h020)
        check($sformatf("pin_out_%0d", i), {24'h0, gpio_pin_out}, vecs[i].exp);
      sel = 1'b0;
      #1;
      check($sformatf("sel0_%0d", i), rdata, 32'h0);
    end

    // Ignored writes: upper lanes only, RO register, unmapped address
    bus_write(14'h000, 32'h77777777, 4'b1110);
    bus_write(14'h020, 32'h12121212, 4'b1110);
    bus_write(14'h010, 32'h00001234, 4'b0001);
    bus_write(14'h030, 32'h000000EE, 4'b0001);
    bus_read("nowr_dfilt", 14'h000, 32'h55);
    bus_read("nowr_out",   14'h020, 32'h55);
    bus_read("nowr_in",    14'h010, 32'h0);
    bus_read("unmapped",   14'h030, 32'h0);
    bus_read("byte_off",   14'h023, 32'h55);

    // Asynchronous reset without clock edge
    @(negedge clk);
    sel = 1'b1; addr = 14'h020;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_pin_out", {24'h0, gpio_pin_out}, 32'h0);
    check("async_rst_rdata", rdata, 32'h0);
    wait_clk(2);
    rst_n = 1'b1;
    bus_read("post_rst_dfilt", 14'h000, 32'h0);

    // Input path, DFILT=0 REFDIV=0
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      gpio_pin_in = pin_pats[i];
      wait_clk(5);
      bus_read($sformatf("pin_in_%0d", i), 14'h010, {19'h0, pin_pats[i]});
    end

`ifdef GPIO_DFILTER_EN
    bus_write(14'h000, 32'h3, 4'b0001);
    bus_write(14'h004, 32'h1, 4'b0001);
    wait_clk(4);
    @(negedge clk);
    gpio_pin_in = 13'h0001;
    repeat (4) @(negedge clk);
    gpio_pin_in = 13'h0000;
    wait_clk(12);
    bus_read("short_pulse", 14'h010, 32'h0);
    @(negedge clk);
    gpio_pin_in = 13'h0001;
    wait_clk(20);
    bus_read("long_hold", 14'h010, 32'h1);
`else
    // Unfiltered input: exactly two synchronizer stages
    @(negedge clk);
    gpio_pin_in = 13'h0001;
    @(posedge clk); #1;
    bus_read("lat_1clk", 14'h010, 32'h0);
    @(posedge clk); #1;
    bus_read("lat_2clk", 14'h010, 32'h1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/top_gpio.md
TOP_GPIO -- requirements
Module: top_gpio

Interface
REQ-001 The block SHALL have one clock and one reset: reset is asynchronous and active-low.
REQ-002 clk  input  1  system clock; all state on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 gpio_pin_in  input  13  external GPIO input pins, asynchronous to clk.
REQ-005 gpio_pin_out  output  8  GPIO output pins, driven from OUT register.
REQ-006 sel  input  1  block select; qualifies reads and writes.
REQ-007 addr  input  14  byte address; decode uses addr[13:2], addr[1:0] ignored.
REQ-008 we  input  4  byte write enables; only we[0] (byte lane 0) acts, we[3:1] ignored.
REQ-009 wdata  input  32  write data; only wdata[7:0] used.
REQ-010 rdata  output  32  read data, combinational.

Function
REQ-011 Register map SHALL be: 0x000 DFILT (8b RW, filter length); 0x004 REFDIV (8b RW, tick prescaler); 0x010 IN (13b RO, filtered pin state); 0x020 OUT (8b RW).
REQ-012 Write SHALL occur on rising clk when sel=1, we[0]=1 and address hits an RW register; the register takes wdata[7:0].
REQ-013 Writes to IN, to unmapped addresses, or with we[0]=0 SHALL have no effect.
REQ-014 rdata SHALL be combinational from sel/addr/registers; zero-extended register value when sel=1 and address mapped; 32'h0 when sel=0 or unmapped.
REQ-015 gpio_pin_out SHALL equal OUT continuously.
REQ-016 Each gpio_pin_in bit SHALL pass a 2-flop synchronizer before use.
REQ-017 A tick SHALL be generated every REFDIV+1 clk cycles from an 8-bit prescaler counter; REFDIV=0 gives a tick every cycle.
REQ-018 Per-bit filter: on each tick, if synced bit equals IN bit the bit counter clears; else the counter increments, and when counter >= DFILT the IN bit takes the synced value and the counter clears.
REQ-019 With DFILT=0, REFDIV=0, a pin change SHALL appear in IN within 4 clk cycles.
REQ-020 A new REFDIV value SHALL take effect at the next prescaler wrap; DFILT applies on the next tick.

Reset
REQ-021 rst_n low SHALL asynchronously clear DFILT, REFDIV, OUT, IN, synchronizer flops, prescaler and filter counters to 0; gpio_pin_out=0; rdata=0 unless sel=1.
REQ-022 Reset mid-filter SHALL discard partial counts; no glitches on gpio_pin_out after release.

Configuration
REQ-023 Macro GPIO_DFILTER_EN defined: filter and prescaler per REQ-017..020.
REQ-024 Macro undefined: IN = synchronizer output directly (latency 2 clk); DFILT/REFDIV remain RW storage with no functional effect.

Structure
REQ-025 Package top_gpio_pkg SHALL hold address constants (0x000, 0x004, 0x010, 0x020), IN width 13, OUT width 8, counter width 8.
REQ-026 Per-bit synchronizer+filter SHALL be sub-module gpio_dfilter, instantiated 13 times (generate); register file/decode stays in top_gpio.

Verification
REQ-027 Release reset, sel=1, read 0x000/0x004/0x010/0x020 -> all 32'h0.
REQ-028 Write wdata 0xAAAAAAAA, 0xFFFFFFFF, 0x0, 0x55555555 with we=4'b0001 to 0x000, 0x004, 0x020 -> readback 0xAA, 0xFF, 0x00, 0x55 in turn; gpio_pin_out follows at 0x020.
REQ-029 After any write, sel=0 -> rdata=32'h0.
REQ-030 Reset, DFILT=0, REFDIV=0; drive gpio_pin_in 0x1FFF, 0x1555, 0x0AAA, 0x0000, wait 5 clk each -> read 0x010 = 0x1FFF, 0x1555, 0x0AAA, 0x0000.
REQ-031 DFILT=3, REFDIV=1, 2-tick pulse on pin 0 -> IN[0] unchanged; hold 8 ticks -> IN[0]=1.
REQ-032 Write with we=4'b1110 or to 0x010 -> no register changes.
